// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - SRAM-like request/response port shared by masters and the bus
interface mem_req_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - fixed-priority fetch/load-store arbiter with grant lock and in-order response routing
module mem_req_arbiter #(
   parameter int MAX_OUT = 2
) (
   input  logic              clk,
   input  logic              rstn,
   mem_req_arbiter_if.slave  inst,
   mem_req_arbiter_if.slave  data,
   mem_req_arbiter_if.master bus,
   output logic              resp_err
);

   localparam int CW = $clog2(MAX_OUT + 1);
   localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   logic               lock_valid;
   logic               lock_id;
   logic               winner;
   logic               win_req;
   logic               fifo_full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               head;
   logic [CW-1:0]      count;
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic [MAX_OUT-1:0] fifo_id;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   // A stalled grant stays with its owner so request fields never change mid-handshake.
   always_comb begin
      winner  = lock_valid ? lock_id : data.req;
      win_req = winner ? data.req : inst.req;
   end

   assign fifo_full = (count == CW'(MAX_OUT));
   assign empty     = (count == '0);

   always_comb begin
      bus.req   = win_req && !fifo_full;
      bus.wr    = inst.wr;
      bus.size  = inst.size;
      bus.wstrb = inst.wstrb;
      bus.addr  = inst.addr;
      bus.wdata = inst.wdata;
      if (winner) begin
         bus.wr    = data.wr;
         bus.size  = data.size;
         bus.wstrb = data.wstrb;
         bus.addr  = data.addr;
         bus.wdata = data.wdata;
      end
   end

   assign push = bus.req && bus.addr_ok;
   assign pop  = bus.data_ok && !empty;
   assign head = fifo_id[rd_ptr];

   assign inst.addr_ok = push && !winner;
   assign data.addr_ok = push && winner;
   assign inst.data_ok = pop && !head;
   assign data.data_ok = pop && head;
   assign inst.rdata   = bus.rdata;
   assign data.rdata   = bus.rdata;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         lock_valid <= 1'b0;
         lock_id    <= 1'b0;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_id    <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (bus.req && !bus.addr_ok) begin
            lock_valid <= 1'b1;
            lock_id    <= winner;
         end else if (push) begin
            lock_valid <= 1'b0;
         end

         if (push) begin
            fifo_id[wr_ptr] <= winner;
            wr_ptr          <= ptr_next(wr_ptr);
         end
         if (pop)
            rd_ptr <= ptr_next(rd_ptr);

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         // A response with nothing outstanding is a protocol error; it is recorded, not routed.
         if (bus.data_ok && empty)
            resp_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - scoreboard bench for mem_req_arbiter
module tb_mem_req_arbiter;
   localparam int MAX_OUT = 2;

   logic clk = 1'b0;
   logic rstn;
   logic resp_err;

   mem_req_arbiter_if inst_if ();
   mem_req_arbiter_if data_if ();
   mem_req_arbiter_if bus_if ();

   mem_req_arbiter #(.MAX_OUT(MAX_OUT)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .inst     (inst_if),
      .data     (data_if),
      .bus      (bus_if),
      .resp_err (resp_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: expected owner IDs of outstanding transfers, oldest first.
   bit m_q[$];
   bit m_lock_v;
   bit m_lock_id;
   bit m_err;

   logic        cap_bus_req, cap_inst_aok, cap_data_aok, cap_inst_dok, cap_data_dok, cap_err;
   logic [31:0] cap_bus_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_lock_v  = 1'b0;
      m_lock_id = 1'b0;
      m_err     = 1'b0;
   endtask

   task automatic cycle();
      bit win, wreq, full, ebreq, hs, pop_e, head_e, spur;
      @(negedge clk);
      win   = m_lock_v ? m_lock_id : data_if.req;
      wreq  = win ? data_if.req : inst_if.req;
      full  = (m_q.size() == MAX_OUT);
      ebreq = wreq && !full;
      hs    = ebreq && bus_if.addr_ok;
      pop_e = bus_if.data_ok && (m_q.size() != 0);
      spur  = bus_if.data_ok && (m_q.size() == 0);
      head_e = pop_e ? m_q[0] : 1'b0;

      cap_bus_req  = bus_if.req;
      cap_bus_addr = bus_if.addr;
      cap_inst_aok = inst_if.addr_ok;
      cap_data_aok = data_if.addr_ok;
      cap_inst_dok = inst_if.data_ok;
      cap_data_dok = data_if.data_ok;
      cap_err      = resp_err;

      check("bus_req", bus_if.req, ebreq);
      check("inst_addr_ok", inst_if.addr_ok, hs && !win);
      check("data_addr_ok", data_if.addr_ok, hs && win);
      if (ebreq) begin
         check("bus_addr", bus_if.addr, win ? data_if.addr : inst_if.addr);
         check("bus_wdata", bus_if.wdata, win ? data_if.wdata : inst_if.wdata);
         check("bus_ctl", {bus_if.wr, bus_if.size, bus_if.wstrb},
               win ? {data_if.wr, data_if.size, data_if.wstrb} : {inst_if.wr, inst_if.size, inst_if.wstrb});
      end
      check("inst_data_ok", inst_if.data_ok, pop_e && !head_e);
      check("data_data_ok", data_if.data_ok, pop_e && head_e);
      if (pop_e)
         check(head_e ? "data_rdata" : "inst_rdata", head_e ? data_if.rdata : inst_if.rdata, bus_if.rdata);
      check("resp_err", resp_err, m_err);

      @(posedge clk);
      if (!rstn) begin
         model_reset();
      end else begin
         if (ebreq && !bus_if.addr_ok) begin
            m_lock_v  = 1'b1;
            m_lock_id = win;
         end else if (hs) begin
            m_lock_v = 1'b0;
         end
         if (pop_e) void'(m_q.pop_front());
         if (hs) m_q.push_back(win);
         if (spur) m_err = 1'b1;
      end
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.wstrb = 4'h0;
      inst_if.addr = 32'h1C000000; inst_if.wdata = 32'h0;
      data_if.req = 0; data_if.wr = 1; data_if.size = 2'd1; data_if.wstrb = 4'h3;
      data_if.addr = 32'h00001000; data_if.wdata = 32'hA5A5_0001;
      bus_if.addr_ok = 0; bus_if.data_ok = 0; bus_if.rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      // Reset state
      cycle();
      check("rst_bus_req", cap_bus_req, 1'b0);
      check("rst_err", cap_err, 1'b0);
      rstn = 1'b1;
      cycle();

      // Fetch only
      inst_if.req = 1; inst_if.addr = 32'h1C000000; bus_if.addr_ok = 1;
      cycle();
      check("fetch_aok", cap_inst_aok, 1'b1);
      inst_if.req = 0; bus_if.addr_ok = 0;
      cycle();
      bus_if.data_ok = 1; bus_if.rdata = 32'h02C00000;
      cycle();
      check("fetch_dok", cap_inst_dok, 1'b1);
      check("fetch_rdata", inst_if.rdata, 32'h02C00000);
      check("fetch_data_dok", cap_data_dok, 1'b0);
      bus_if.data_ok = 0;

      // Simultaneous requests: data first
      inst_if.req = 1; inst_if.addr = 32'h1C000004;
      data_if.req = 1; data_if.addr = 32'h00001000; bus_if.addr_ok = 1;
      cycle();
      check("sim_data_first", cap_bus_addr, 32'h00001000);
      check("sim_data_aok", cap_data_aok, 1'b1);
      data_if.req = 0;
      cycle();
      check("sim_inst_second", cap_bus_addr, 32'h1C000004);
      inst_if.req = 0; bus_if.addr_ok = 0;
      cycle();
      bus_if.data_ok = 1; bus_if.rdata = 32'h1111_2222;
      cycle();
      check("sim_resp0_data", cap_data_dok, 1'b1);
      bus_if.rdata = 32'h3333_4444;
      cycle();
      check("sim_resp1_inst", cap_inst_dok, 1'b1);
      bus_if.data_ok = 0;

      // Lock: inst stalled, data arrives later and must wait
      inst_if.req = 1; inst_if.addr = 32'h1C000004; bus_if.addr_ok = 0;
      cycle();
      data_if.req = 1; data_if.addr = 32'h00002000;
      cycle();
      check("lock_addr_c1", cap_bus_addr, 32'h1C000004);
      cycle();
      check("lock_addr_c2", cap_bus_addr, 32'h1C000004);
      bus_if.addr_ok = 1;
      cycle();
      check("lock_inst_hs", cap_inst_aok, 1'b1);
      check("lock_data_wait", cap_data_aok, 1'b0);
      inst_if.req = 0;
      cycle();
      check("lock_data_hs", cap_bus_addr, 32'h00002000);
      data_if.req = 0; bus_if.addr_ok = 0;
      bus_if.data_ok = 1; bus_if.rdata = 32'h5555_6666;
      cycle();
      bus_if.rdata = 32'h7777_8888;
      cycle();
      bus_if.data_ok = 0;

      // Full FIFO blocks; a same-cycle pop does not unblock
      inst_if.req = 1; inst_if.addr = 32'h1C000010; bus_if.addr_ok = 1;
      cycle();
      cycle();
      cycle();
      check("full_blocked", cap_bus_req, 1'b0);
      check("full_no_aok", cap_inst_aok, 1'b0);
      bus_if.data_ok = 1; bus_if.rdata = 32'h0000_00F1;
      cycle();
      check("full_pop_cycle", cap_bus_req, 1'b0);
      bus_if.data_ok = 0;
      cycle();
      check("full_unblocked", cap_bus_req, 1'b1);
      inst_if.req = 0; bus_if.addr_ok = 0; bus_if.data_ok = 1;
      cycle();
      cycle();
      bus_if.data_ok = 0;

      // Back-to-back push+pop with one outstanding
      inst_if.req = 1; bus_if.addr_ok = 1;
      cycle();
      for (int i = 0; i < 8; i++) begin
         logic pick;
         pick = 1'($urandom_range(0, 1));
         inst_if.req = !pick; data_if.req = pick;
         inst_if.addr = 32'h1C000100 + 32'(i * 4);
         data_if.addr = $urandom; data_if.wdata = $urandom;
         bus_if.data_ok = 1; bus_if.rdata = $urandom;
         cycle();
         check("b2b_not_full", cap_bus_req, 1'b1);
      end
      inst_if.req = 0; data_if.req = 0; bus_if.addr_ok = 0;
      cycle();
      bus_if.data_ok = 0;
      cycle();

      // Spurious response after reset
      rstn = 0;
      cycle();
      rstn = 1;
      bus_if.data_ok = 1; bus_if.rdata = 32'hDEAD_BEEF;
      cycle();
      check("spur_inst_dok", cap_inst_dok, 1'b0);
      check("spur_data_dok", cap_data_dok, 1'b0);
      bus_if.data_ok = 0;
      cycle();
      check("spur_err_set", cap_err, 1'b1);
      cycle();
      check("spur_err_sticky", cap_err, 1'b1);
      rstn = 0;
      cycle();
      rstn = 1;
      cycle();
      check("spur_err_cleared", cap_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Two-master arbiter that shares the single SRAM-like memory port between the instruction-fetch requester and the load/store requester. It sits between the pipeline (Fetch and Execute/Memory stages) and the bus bridge. It grants address phases by fixed priority with grant locking, and routes in-order `data_ok`/`rdata` responses back to the owning master through an outstanding-transaction ID FIFO.

## Interface
- `MAX_OUT`, 2: maximum outstanding (address-accepted, data-pending) transactions; legal values 1..4.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `inst_req` in 1, `inst_wr` in 1, `inst_size` in 2, `inst_wstrb` in 4, `inst_addr` in 32, `inst_wdata` in 32: fetch master request.
- `inst_addr_ok` out 1, `inst_data_ok` out 1, `inst_rdata` out 32: fetch master response.
- `data_req` in 1, `data_wr` in 1, `data_size` in 2, `data_wstrb` in 4, `data_addr` in 32, `data_wdata` in 32: load/store master request.
- `data_addr_ok` out 1, `data_data_ok` out 1, `data_rdata` out 32: load/store master response.
- `bus_req` out 1, `bus_wr` out 1, `bus_size` out 2, `bus_wstrb` out 4, `bus_addr` out 32, `bus_wdata` out 32: shared port request.
- `bus_addr_ok` in 1, `bus_data_ok` in 1, `bus_rdata` in 32: shared port response.
- `resp_err` out 1: sticky; set on `bus_data_ok` with FIFO empty.

## Operation
- Address handshake: a transfer is accepted when `bus_req && bus_addr_ok`. Masters hold request fields stable from `req` assertion until their `addr_ok`.
- Grant select, combinational:
  - If `lock_valid` is set, the winner is `lock_id`.
  - Otherwise the winner is data (ID 1) when `data_req` is set, else inst (ID 0) when `inst_req` is set.
- Lock register:
  - Set `lock_valid` and `lock_id` = winner on the next edge when `bus_req && !bus_addr_ok`.
  - Clear `lock_valid` on handshake.
  - A locked grant is never pre-empted, even if data asserts while inst is locked.
- Bus request fields mux from the winner. `bus_req` = winner's req && `!fifo_full`.
- `X_addr_ok` = `bus_addr_ok && bus_req && winner==X`. The loser's `addr_ok` is 0.
- ID FIFO:
  - Depth `MAX_OUT`, 1-bit entries, pointers wrap modulo `MAX_OUT`, count width clog2(`MAX_OUT`+1).
  - Push the winner ID on handshake. Pop on `bus_data_ok` when not empty.
- `fifo_full` (count == `MAX_OUT`) blocks new requests. It is evaluated on the registered count only, so a same-cycle pop does not unblock the request.
- Response routing: `X_data_ok` = `bus_data_ok && !empty && head==X`.
  - `inst_rdata` and `data_rdata` both carry `bus_rdata` unconditionally; consumers qualify with `data_ok`.
  - Writes also return `data_ok` and are routed identically.
- Simultaneous push and pop: count unchanged, both pointers advance. A response may return in the same cycle as a new address handshake.
- Spurious `bus_data_ok` with FIFO empty:
  - Sets `resp_err`.
  - No pointer or count change.
  - Both `data_ok` outputs are 0.
- Pipeline flush is the masters' concern: accepted transactions always complete, and the requester discards flushed responses. The arbiter never cancels.

## Timing
- Reset values:
  - Registers: `lock_valid`=0, `lock_id`=0, count=0, rd/wr pointers=0, `resp_err`=0.
  - Outputs with all reqs low: `bus_req`=0, `inst_addr_ok`=`data_addr_ok`=0, `inst_data_ok`=`data_data_ok`=0.
- Zero-cycle latency: request-to-bus and response-to-master paths are combinational. There are no added stall cycles.
- A handshake at edge N makes the ID visible at the FIFO head from cycle N+1. A `bus_data_ok` in cycle N+1 is routed correctly.
- Reset asserted mid-transaction clears all state at that edge. Outstanding bus responses arriving afterward set `resp_err`; the bridge is reset together with this block.
- `MAX_OUT`=1 gives strictly alternating address/data phases.

## Test plan
- Fetch only: `inst_req`=1, addr 0x1C000000, `bus_addr_ok`=1 cycle 0, `bus_data_ok` with rdata 0x02C00000 cycle 2 -> `inst_addr_ok`=1 cycle 0, `inst_data_ok`=1, `inst_rdata`=0x02C00000 cycle 2, `data_data_ok`=0.
- Simultaneous requests, `bus_addr_ok`=1 -> data (addr 0x1000) granted cycle 0, inst (addr 0x1C000004) cycle 1; responses in cycles 3 and 4 go to data then inst.
- Lock: inst requests, `bus_addr_ok`=0 for 3 cycles, `data_req` asserted cycle 1 -> bus_addr stays 0x1C000004 until the inst handshake in cycle 3; data granted cycle 4.
- Full: `MAX_OUT`=2, two accepted with no `data_ok` -> third `bus_req`=0 and `addr_ok`=0. A `data_ok` in cycle k unblocks the request in cycle k+1, not cycle k.
- Same-cycle push and pop with count=1 -> count stays 1 and IDs remain in order over 8 back-to-back mixed transfers.
- Spurious `bus_data_ok` after reset -> `resp_err`=1 stays set, both `data_ok` outputs are 0, count=0. `rstn`=0 clears `resp_err` next edge.
